nn_iter_controller: RTL and testbench
=====================================

Name: nn_iter_controller

Overview:
- Parametrised Moore FSM controller for iterative neural-network datapaths (e.g. MaxNet-style winner search).
- Sequences load, initial register select, compute, pipeline wait and update/writeback.
- Adds an iteration counter, a max-iteration timeout, a configurable pipeline wait length and an abort input.
- Sits between the top-level start/done handshake and the datapath register enables and mux select.

Parameters:
- ITER_W, 8: width of the iteration counter and the iter_count output.
- MAX_ITER, 255: maximum number of update iterations before a forced finish. Legal range is 1 to 2^ITER_W-1.
- PIPE_LAT, 1: number of WAIT cycles between COMPUTE and UPDATE. 0 means WAIT is skipped. Legal range is 0 to 15.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin an operation. Sampled only in IDLE.
- complete, input, 1: datapath convergence flag. Sampled only in UPDATE.
- abort, input, 1: cancel the current operation. Sampled in any non-IDLE state.
- sel, output, 1: datapath mux select. 1 selects the initial/loaded values; 0 selects the feedback values.
- en0, output, 1: input-register load enable.
- en1, output, 1: working-register write enable.
- en2, output, 1: compute-stage register enable.
- en3, output, 1: result/output-register enable.
- done, output, 1: one-cycle completion pulse.
- busy, output, 1: high in every state except IDLE.
- timeout, output, 1: registered flag. Set when the run ended on MAX_ITER instead of complete.
- iter_count, output, ITER_W: number of UPDATE cycles in the current or last run.

Behaviour:
- States: IDLE, LOAD, INIT, COMPUTE, WAIT, UPDATE, DONE.
- rst_n low forces, asynchronously:
  - state to IDLE;
  - iter_count to 0;
  - timeout to 0;
  - wait counter to 0.
- All enables, sel, done and busy decode combinationally from the state only (Moore). In reset they are all 0.
- Output decode (signals not listed are 0):
  - IDLE: nothing asserted.
  - LOAD: en0=1.
  - INIT: sel=1, en1=1.
  - COMPUTE: en2=1.
  - WAIT: nothing asserted.
  - UPDATE: en1=1, en3=1, sel=0.
  - DONE: done=1.
- Transitions:
  - IDLE goes to LOAD when start=1, otherwise stays in IDLE.
  - LOAD goes to INIT. On entry to LOAD, iter_count clears to 0 and timeout clears to 0.
  - INIT goes to COMPUTE.
  - COMPUTE goes to WAIT if PIPE_LAT>0, otherwise to UPDATE. On the COMPUTE-to-WAIT edge the wait counter loads PIPE_LAT-1.
  - WAIT: decrement the wait counter each cycle. When the counter is 0, go to UPDATE. WAIT therefore lasts exactly PIPE_LAT cycles.
  - UPDATE: iter_count increments by 1 on exit. Then:
    - if complete=1, go to DONE;
    - else if iter_count+1 == MAX_ITER, go to DONE and set timeout=1;
    - else go to COMPUTE.
  - DONE goes to IDLE unconditionally.
- abort=1 in LOAD, INIT, COMPUTE, WAIT or UPDATE forces the next state to IDLE. In that case:
  - no done pulse is produced;
  - timeout is unchanged;
  - iter_count holds its value;
  - abort has priority over complete and over the MAX_ITER check.
- abort in DONE has no effect; done still pulses. abort in IDLE is ignored.
- start outside IDLE is ignored. start held high through DONE relaunches on the cycle after returning to IDLE.
- complete and MAX_ITER on the same UPDATE: complete wins, so timeout stays 0.
- iter_count never wraps, because MAX_ITER ≤ 2^ITER_W-1. It holds its final value until the next LOAD.
- Latency with PIPE_LAT=1, start seen in cycle 0:
  - LOAD@1, INIT@2, COMPUTE@3, WAIT@4, UPDATE@5;
  - with complete=1, done@6 and IDLE@7.
  - Each extra iteration adds 2+PIPE_LAT cycles.
- rst_n asserted mid-run returns to IDLE immediately. No done pulse is produced and all registers are cleared.

Test Plan:
- Reset, then start pulse with PIPE_LAT=1 and complete=1 at the first UPDATE. Required:
  - en0@1, sel&en1@2, en2@3, idle outputs@4, en1&en3@5 with sel=0, done@6;
  - iter_count=1, timeout=0, busy high in cycles 1–6.
- complete held low until the 3rd UPDATE, PIPE_LAT=1. Required: UPDATE in cycles 5, 8 and 11, done@12, iter_count=3.
- MAX_ITER=4 with complete never asserted. Required: done after the 4th UPDATE, timeout=1, iter_count=4. A subsequent start clears timeout in LOAD.
- PIPE_LAT=0 and PIPE_LAT=3 builds with complete=1 on the first UPDATE. Required: done@5 and done@8 respectively.
- abort asserted in WAIT during the 2nd iteration. Required: IDLE next cycle, no done pulse, iter_count=1. start asserted during the run is ignored.
- rst_n dropped asynchronously mid-COMPUTE. Required: immediately all outputs 0, iter_count=0, state IDLE. Operation resumes normally after rst_n rises.

Source files
------------

// File: rtl/nn_iter_controller_if.sv
// Handshake and control bundle between the iterative NN controller and its host/datapath.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; start/abort are level inputs, done is a single-cycle pulse.
// Ports (slave = controller side):
//   start, complete, abort     host/datapath -> controller
//   sel, en0..en3              controller -> datapath mux select and register enables
//   done, busy, timeout        controller -> host status
//   iter_count [ITER_W]        controller -> host, UPDATE count of the current/last run
interface nn_iter_controller_if #(
  parameter int ITER_W = 8
);
  logic              start;
  logic              complete;
  logic              abort;
  logic              sel;
  logic              en0;
  logic              en1;
  logic              en2;
  logic              en3;
  logic              done;
  logic              busy;
  logic              timeout;
  logic [ITER_W-1:0] iter_count;

  // Host/datapath side: drives the requests and consumes the enables/status.
  modport master (
    output start, complete, abort,
    input  sel, en0, en1, en2, en3, done, busy, timeout, iter_count
  );

  // Controller side.
  modport slave (
    input  start, complete, abort,
    output sel, en0, en1, en2, en3, done, busy, timeout, iter_count
  );
endinterface

// File: rtl/nn_iter_controller.sv
// Moore FSM sequencing LOAD/INIT/COMPUTE/WAIT/UPDATE for iterative NN datapaths (e.g. MaxNet).
// Latency: start -> LOAD next cycle; each iteration costs 2+PIPE_LAT cycles; done one cycle after last UPDATE.
// Backpressure: none; abort in any busy state (except DONE) returns to IDLE on the next edge.
// Ports: clk, rst_n (async active-low), bus (slave modport of nn_iter_controller_if).
module nn_iter_controller #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int PIPE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  nn_iter_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_COMPUTE,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
  // Counter is loaded with PIPE_LAT-1 so that WAIT spans exactly PIPE_LAT cycles.
  localparam logic [3:0]        WAIT_INIT  = (PIPE_LAT > 0) ? 4'(PIPE_LAT - 1) : 4'd0;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ITER_W-1:0] iter_count;
  logic              timeout;
  logic [ITER_W-1:0] iter_next;

  assign iter_next = iter_count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      iter_count <= '0;
      timeout    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_LOAD;
            // Cleared on entry to LOAD so the last run's result stays visible until relaunch.
            iter_count <= '0;
            timeout    <= 1'b0;
          end
        end
        S_LOAD: begin
          state <= bus.abort ? S_IDLE : S_INIT;
        end
        S_INIT: begin
          state <= bus.abort ? S_IDLE : S_COMPUTE;
        end
        S_COMPUTE: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else if (PIPE_LAT > 0) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_INIT;
          end else begin
            state <= S_UPDATE;
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= S_UPDATE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_UPDATE: begin
          // abort outranks both convergence and the iteration limit; count holds on abort.
          if (bus.abort) begin
            state <= S_IDLE;
          end else begin
            iter_count <= iter_next;
            if (bus.complete) begin
              state <= S_DONE;
            end else if (iter_next == MAX_ITER_C) begin
              state   <= S_DONE;
              timeout <= 1'b1;
            end else begin
              state <= S_COMPUTE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode: outputs depend on state only.
  logic sel_d, en0_d, en1_d, en2_d, en3_d, done_d, busy_d;

  always_comb begin
    sel_d  = 1'b0;
    en0_d  = 1'b0;
    en1_d  = 1'b0;
    en2_d  = 1'b0;
    en3_d  = 1'b0;
    done_d = 1'b0;
    busy_d = (state != S_IDLE);
    case (state)
      S_LOAD:    en0_d = 1'b1;
      S_INIT: begin
        sel_d = 1'b1;
        en1_d = 1'b1;
      end
      S_COMPUTE: en2_d = 1'b1;
      S_UPDATE: begin
        en1_d = 1'b1;
        en3_d = 1'b1;
      end
      S_DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.sel        = sel_d;
  assign bus.en0        = en0_d;
  assign bus.en1        = en1_d;
  assign bus.en2        = en2_d;
  assign bus.en3        = en3_d;
  assign bus.done       = done_d;
  assign bus.busy       = busy_d;
  assign bus.timeout    = timeout;
  assign bus.iter_count = iter_count;

endmodule

// File: tb/tb_nn_iter_controller.sv
// Bench for nn_iter_controller: four builds (default, MAX_ITER=4, PIPE_LAT=0, PIPE_LAT=3).
// Expected per-cycle output vectors are queued when a run is launched and popped each cycle.
// Vector bit order: {sel, en0, en1, en2, en3, done, busy}.
module tb_nn_iter_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nn_iter_controller_if #(.ITER_W(8)) ifa ();
  nn_iter_controller_if #(.ITER_W(8)) ifb ();
  nn_iter_controller_if #(.ITER_W(8)) ifc ();
  nn_iter_controller_if #(.ITER_W(8)) ifd ();

  nn_iter_controller #(.ITER_W(8), .MAX_ITER(255), .PIPE_LAT(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  nn_iter_controller #(.ITER_W(8), .MAX_ITER(4),   .PIPE_LAT(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  nn_iter_controller #(.ITER_W(8), .MAX_ITER(255), .PIPE_LAT(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  nn_iter_controller #(.ITER_W(8), .MAX_ITER(255), .PIPE_LAT(3)) u_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

  typedef enum int {P_IDLE, P_LOAD, P_INIT, P_COMP, P_WAIT, P_UPD, P_DONE} ph_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] exp_q[$];
  logic [6:0] got;
  logic [6:0] want;

  function automatic logic [6:0] dec(ph_t p);
    case (p)
      P_LOAD:  return 7'b0100001;
      P_INIT:  return 7'b1010001;
      P_COMP:  return 7'b0001001;
      P_WAIT:  return 7'b0000001;
      P_UPD:   return 7'b0010101;
      P_DONE:  return 7'b0000011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] obs(int k);
    case (k)
      0:       return {ifa.sel, ifa.en0, ifa.en1, ifa.en2, ifa.en3, ifa.done, ifa.busy};
      1:       return {ifb.sel, ifb.en0, ifb.en1, ifb.en2, ifb.en3, ifb.done, ifb.busy};
      2:       return {ifc.sel, ifc.en0, ifc.en1, ifc.en2, ifc.en3, ifc.done, ifc.busy};
      default: return {ifd.sel, ifd.en0, ifd.en1, ifd.en2, ifd.en3, ifd.done, ifd.busy};
    endcase
  endfunction

  function automatic logic [7:0] cnt(int k);
    case (k)
      0:       return ifa.iter_count;
      1:       return ifb.iter_count;
      2:       return ifc.iter_count;
      default: return ifd.iter_count;
    endcase
  endfunction

  function automatic logic tmo(int k);
    case (k)
      0:       return ifa.timeout;
      1:       return ifb.timeout;
      2:       return ifc.timeout;
      default: return ifd.timeout;
    endcase
  endfunction

  // Reference schedule of a run: LOAD, INIT, n x (COMPUTE, WAIT^pipe, UPDATE), DONE, IDLE.
  task automatic push_run(int pipe, int n_upd);
    exp_q.push_back(dec(P_LOAD));
    exp_q.push_back(dec(P_INIT));
    for (int u = 0; u < n_upd; u++) begin
      exp_q.push_back(dec(P_COMP));
      for (int w = 0; w < pipe; w++) exp_q.push_back(dec(P_WAIT));
      exp_q.push_back(dec(P_UPD));
    end
    exp_q.push_back(dec(P_DONE));
    exp_q.push_back(dec(P_IDLE));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifa.start = 0; ifa.complete = 0; ifa.abort = 0;
    ifb.start = 0; ifb.complete = 0; ifb.abort = 0;
    ifc.start = 0; ifc.complete = 0; ifc.abort = 0;
    ifd.start = 0; ifd.complete = 0; ifd.abort = 0;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (obs(k) !== 7'b0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d got %b want %b", k, obs(k), 7'b0);
      end
      n_vec++;
      if (cnt(k) !== 8'd0 || tmo(k) !== 1'b0) begin
        n_err++;
        $display("FAIL reset_regs dut%0d got iter=%0d tmo=%b want iter=0 tmo=0", k, cnt(k), tmo(k));
      end
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    ifa.complete = 1; ifa.start = 1;
    push_run(1, 1);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      ifa.start = 0;
      got = obs(0); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL single c%0d got %b want %b", c, got, want);
      end
    end
    n_vec++;
    if (ifa.iter_count !== 8'd1 || ifa.timeout !== 1'b0) begin
      n_err++;
      $display("FAIL single_end got iter=%0d tmo=%b want iter=1 tmo=0", ifa.iter_count, ifa.timeout);
    end
    ifa.complete = 0;
  endtask

  task automatic test_multi_iter();
    ifa.start = 1; ifa.complete = 0;
    push_run(1, 3);
    for (int c = 1; c <= 13; c++) begin
      next_cycle();
      ifa.start = 0;
      ifa.complete = (c == 11);
      got = obs(0); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL multi_iter c%0d got %b want %b", c, got, want);
      end
    end
    ifa.complete = 0;
    n_vec++;
    if (ifa.iter_count !== 8'd3 || ifa.timeout !== 1'b0) begin
      n_err++;
      $display("FAIL multi_iter_end got iter=%0d tmo=%b want iter=3 tmo=0", ifa.iter_count, ifa.timeout);
    end
  endtask

  task automatic test_timeout();
    // Run 1: complete never asserted, forced finish after the 4th UPDATE.
    ifb.start = 1; ifb.complete = 0;
    push_run(1, 4);
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      ifb.start = 0;
      got = obs(1); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL timeout c%0d got %b want %b", c, got, want);
      end
    end
    n_vec++;
    if (ifb.iter_count !== 8'd4 || ifb.timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_end got iter=%0d tmo=%b want iter=4 tmo=1", ifb.iter_count, ifb.timeout);
    end
    // Run 2: relaunch clears timeout in LOAD; complete on the limit UPDATE wins.
    ifb.start = 1;
    push_run(1, 4);
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      ifb.start = 0;
      ifb.complete = (c == 14);
      if (c == 1) begin
        n_vec++;
        if (ifb.timeout !== 1'b0 || ifb.iter_count !== 8'd0) begin
          n_err++;
          $display("FAIL timeout_clear got iter=%0d tmo=%b want iter=0 tmo=0", ifb.iter_count, ifb.timeout);
        end
      end
      got = obs(1); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL complete_at_limit c%0d got %b want %b", c, got, want);
      end
    end
    ifb.complete = 0;
    n_vec++;
    if (ifb.iter_count !== 8'd4 || ifb.timeout !== 1'b0) begin
      n_err++;
      $display("FAIL complete_at_limit_end got iter=%0d tmo=%b want iter=4 tmo=0", ifb.iter_count, ifb.timeout);
    end
  endtask

  task automatic test_pipe_lat();
    int done_c;
    int lat;
    int ncyc;
    int want_done;
    for (int k = 2; k <= 3; k++) begin
      lat       = (k == 2) ? 0 : 3;
      ncyc      = 5 + lat + 1;
      want_done = 5 + lat;
      done_c    = -1;
      if (k == 2) begin ifc.start = 1; ifc.complete = 1; end
      else        begin ifd.start = 1; ifd.complete = 1; end
      push_run(lat, 1);
      for (int c = 1; c <= ncyc; c++) begin
        next_cycle();
        ifc.start = 0; ifd.start = 0;
        got = obs(k); want = exp_q.pop_front();
        if (got[1] && done_c < 0) done_c = c;
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL pipe_lat%0d c%0d got %b want %b", lat, c, got, want);
        end
      end
      n_vec++;
      if (done_c != want_done) begin
        n_err++;
        $display("FAIL pipe_lat%0d_done_cycle got %0d want %0d", lat, done_c, want_done);
      end
    end
    ifc.complete = 0; ifd.complete = 0;
  endtask

  task automatic test_abort();
    // Abort in WAIT of the 2nd iteration; stray starts mid-run are ignored.
    ifa.start = 1; ifa.complete = 0; ifa.abort = 0;
    exp_q.push_back(dec(P_LOAD)); exp_q.push_back(dec(P_INIT));
    exp_q.push_back(dec(P_COMP)); exp_q.push_back(dec(P_WAIT));
    exp_q.push_back(dec(P_UPD));  exp_q.push_back(dec(P_COMP));
    exp_q.push_back(dec(P_WAIT)); exp_q.push_back(dec(P_IDLE));
    exp_q.push_back(dec(P_IDLE));
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      ifa.start = (c >= 3 && c <= 5);
      ifa.abort = (c == 7);
      got = obs(0); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL abort_wait c%0d got %b want %b", c, got, want);
      end
    end
    n_vec++;
    if (ifa.iter_count !== 8'd1 || ifa.timeout !== 1'b0) begin
      n_err++;
      $display("FAIL abort_wait_end got iter=%0d tmo=%b want iter=1 tmo=0", ifa.iter_count, ifa.timeout);
    end
    // Abort together with complete in UPDATE: abort wins, count holds.
    ifa.start = 1;
    exp_q.push_back(dec(P_LOAD)); exp_q.push_back(dec(P_INIT));
    exp_q.push_back(dec(P_COMP)); exp_q.push_back(dec(P_WAIT));
    exp_q.push_back(dec(P_UPD));  exp_q.push_back(dec(P_IDLE));
    exp_q.push_back(dec(P_IDLE));
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      ifa.start = 0;
      ifa.abort = (c == 5);
      ifa.complete = (c == 5);
      got = obs(0); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL abort_update c%0d got %b want %b", c, got, want);
      end
    end
    n_vec++;
    if (ifa.iter_count !== 8'd0) begin
      n_err++;
      $display("FAIL abort_update_iter got %0d want 0", ifa.iter_count);
    end
  endtask

  task automatic test_back_to_back();
    ifa.start = 1; ifa.complete = 1;
    push_run(1, 1);
    push_run(1, 1);
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      ifa.start = (c < 8);
      got = obs(0); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL back_to_back c%0d got %b want %b", c, got, want);
      end
    end
    ifa.complete = 0;
    n_vec++;
    if (ifa.iter_count !== 8'd1) begin
      n_err++;
      $display("FAIL back_to_back_iter got %0d want 1", ifa.iter_count);
    end
  endtask

  task automatic test_async_reset();
    ifa.start = 1; ifa.complete = 0;
    exp_q.push_back(dec(P_LOAD)); exp_q.push_back(dec(P_INIT));
    exp_q.push_back(dec(P_COMP)); exp_q.push_back(dec(P_WAIT));
    exp_q.push_back(dec(P_UPD));  exp_q.push_back(dec(P_COMP));
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      ifa.start = 0;
      got = obs(0); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL rst_pre c%0d got %b want %b", c, got, want);
      end
    end
    n_vec++;
    if (ifa.iter_count !== 8'd1) begin
      n_err++;
      $display("FAIL rst_pre_iter got %0d want 1", ifa.iter_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs(0) !== 7'b0 || ifa.iter_count !== 8'd0 || ifa.timeout !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid got out=%b iter=%0d tmo=%b want out=0 iter=0 tmo=0", obs(0), ifa.iter_count, ifa.timeout);
    end
    #2 rst_n = 1'b1;
    next_cycle();
    n_vec++;
    if (obs(0) !== 7'b0) begin
      n_err++;
      $display("FAIL rst_release got %b want %b", obs(0), 7'b0);
    end
    ifa.start = 1; ifa.complete = 1;
    push_run(1, 1);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      ifa.start = 0;
      got = obs(0); want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL rst_resume c%0d got %b want %b", c, got, want);
      end
    end
    ifa.complete = 0;
    n_vec++;
    if (ifa.iter_count !== 8'd1) begin
      n_err++;
      $display("FAIL rst_resume_iter got %0d want 1", ifa.iter_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi_iter();
    test_timeout();
    test_pipe_lat();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
